// File: rtl/game_flow_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : game_flow_ctrl_if
//  Description : Bundles the button/event pulses feeding the game-flow
//                sequencer and the state enables / status counters it
//                returns.
//                master : drives the event inputs, observes state/status
//                slave  : the sequencer itself
//  Ports       : tick, start, pause, esc_pause, restart, level_sel,
//                level_clear, life_lost                   (master -> slave)
//                choose_en, ready_en, playing_en, pause_en, over_en, win_en,
//                level, lives, countdown, play_time       (slave -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface game_flow_ctrl_if #(
   parameter int LVL_W  = 2,
   parameter int LIFE_W = 2,
   parameter int CNT_W  = 2,
   parameter int TIME_W = 10
);
   logic              tick;
   logic              start;
   logic              pause;
   logic              esc_pause;
   logic              restart;
   logic [LVL_W-1:0]  level_sel;
   logic              level_clear;
   logic              life_lost;

   logic              choose_en;
   logic              ready_en;
   logic              playing_en;
   logic              pause_en;
   logic              over_en;
   logic              win_en;
   logic [LVL_W-1:0]  level;
   logic [LIFE_W-1:0] lives;
   logic [CNT_W-1:0]  countdown;
   logic [TIME_W-1:0] play_time;

   modport master (
      output tick, start, pause, esc_pause, restart, level_sel,
             level_clear, life_lost,
      input  choose_en, ready_en, playing_en, pause_en, over_en, win_en,
             level, lives, countdown, play_time
   );

   modport slave (
      input  tick, start, pause, esc_pause, restart, level_sel,
             level_clear, life_lost,
      output choose_en, ready_en, playing_en, pause_en, over_en, win_en,
             level, lives, countdown, play_time
   );
endinterface
`default_nettype wire

// File: rtl/game_flow_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : game_flow_ctrl
//  Description : Game-flow sequencer: CHOOSE -> READY (countdown) -> PLAYING
//                with PAUSE, multi-level progression, a life counter, OVER
//                and WIN end states, and a saturating play-time counter.
//  Ports       : clk   - system clock, rising edge
//                rstn  - asynchronous active-low reset
//                bus   - game_flow_ctrl_if.slave (event pulses in,
//                        one-hot state enables and status counters out)
//  Revision    : 1.0  initial release
// ============================================================================
module game_flow_ctrl #(
   parameter int NUM_LEVELS = 4,
   parameter int LVL_W      = 2,
   parameter int MAX_LIVES  = 3,
   parameter int LIFE_W     = 2,
   parameter int COUNTDOWN  = 3,
   parameter int CNT_W      = 2,
   parameter int TIME_W     = 10
) (
   input  wire logic         clk,
   input  wire logic         rstn,
   game_flow_ctrl_if.slave   bus
);

   localparam logic [LVL_W-1:0]  C_LAST_LEVEL = LVL_W'(NUM_LEVELS - 1);
   localparam logic [LIFE_W-1:0] C_MAX_LIVES  = LIFE_W'(MAX_LIVES);
   localparam logic [CNT_W-1:0]  C_COUNTDOWN  = CNT_W'(COUNTDOWN);
   localparam logic [TIME_W-1:0] C_TIME_MAX   = '1;

   typedef enum logic [2:0] {
      S_CHOOSE  = 3'd0,
      S_READY   = 3'd1,
      S_PLAYING = 3'd2,
      S_PAUSE   = 3'd3,
      S_OVER    = 3'd4,
      S_WIN     = 3'd5
   } state_t;

   state_t            state_q,     state_d;
   logic [LVL_W-1:0]  level_q,     level_d;
   logic [LIFE_W-1:0] lives_q,     lives_d;
   logic [CNT_W-1:0]  countdown_q, countdown_d;
   logic [TIME_W-1:0] play_time_q, play_time_d;

   // ------------------------------------------------------------------------
   // State and counter registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_CHOOSE;
         level_q     <= '0;
         lives_q     <= C_MAX_LIVES;
         countdown_q <= C_COUNTDOWN;
         play_time_q <= '0;
      end else begin
         state_q     <= state_d;
         level_q     <= level_d;
         lives_q     <= lives_d;
         countdown_q <= countdown_d;
         play_time_q <= play_time_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and counter update
   // ------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      level_d     = level_q;
      lives_d     = lives_q;
      countdown_d = countdown_q;
      play_time_d = play_time_q;

      case (state_q)
         S_CHOOSE: begin
            // restart is meaningless here; only start is honoured
            if (bus.start) begin
               state_d     = S_READY;
               level_d     = (bus.level_sel > C_LAST_LEVEL) ? C_LAST_LEVEL
                                                            : bus.level_sel;
               lives_d     = C_MAX_LIVES;
               countdown_d = C_COUNTDOWN;
               play_time_d = '0;
            end
         end

         S_READY: begin
            if (bus.restart) begin
               state_d = S_CHOOSE;
            end else if (bus.tick) begin
               // <= 1 rather than == 1 so a zero count can never stall here
               if (countdown_q <= CNT_W'(1)) begin
                  countdown_d = '0;
                  state_d     = S_PLAYING;
               end else begin
                  countdown_d = countdown_q - 1'b1;
               end
            end
         end

         S_PLAYING: begin
            if (bus.restart) begin
               state_d = S_CHOOSE;
            end else begin
               // The tick is counted even when this cycle leaves PLAYING
               if (bus.tick && (play_time_q != C_TIME_MAX)) begin
                  play_time_d = play_time_q + 1'b1;
               end

               if (bus.pause) begin
                  state_d = S_PAUSE;
               end else if (bus.life_lost) begin
                  lives_d = lives_q - 1'b1;
                  if (lives_q == LIFE_W'(1)) begin
                     state_d = S_OVER;
                  end else begin
                     countdown_d = C_COUNTDOWN;
                     state_d     = S_READY;
                  end
               end else if (bus.level_clear) begin
                  if (level_q == C_LAST_LEVEL) begin
                     state_d = S_WIN;
                  end else begin
                     level_d     = level_q + 1'b1;
                     countdown_d = C_COUNTDOWN;
                     state_d     = S_READY;
                  end
               end
            end
         end

         S_PAUSE: begin
            if (bus.restart) begin
               state_d = S_CHOOSE;
            end else if (bus.esc_pause) begin
               state_d = S_PLAYING;
            end
         end

         S_OVER, S_WIN: begin
            if (bus.restart) begin
               state_d = S_CHOOSE;
            end
         end

         default: begin
            state_d = S_CHOOSE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // One-hot enables decoded from the state register only. An illegal
   // encoding is shown as CHOOSE, matching where it recovers to.
   // ------------------------------------------------------------------------
   always_comb begin
      bus.choose_en  = 1'b0;
      bus.ready_en   = 1'b0;
      bus.playing_en = 1'b0;
      bus.pause_en   = 1'b0;
      bus.over_en    = 1'b0;
      bus.win_en     = 1'b0;
      case (state_q)
         S_CHOOSE:  bus.choose_en  = 1'b1;
         S_READY:   bus.ready_en   = 1'b1;
         S_PLAYING: bus.playing_en = 1'b1;
         S_PAUSE:   bus.pause_en   = 1'b1;
         S_OVER:    bus.over_en    = 1'b1;
         S_WIN:     bus.win_en     = 1'b1;
         default:   bus.choose_en  = 1'b1;
      endcase
   end

   assign bus.level     = level_q;
   assign bus.lives     = lives_q;
   assign bus.countdown = countdown_q;
   assign bus.play_time = play_time_q;

endmodule
`default_nettype wire

// File: tb/tb_game_flow_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_flow_ctrl
//  Description : Self-checking bench for game_flow_ctrl. Directed scenarios
//                check against fixed expected values; a random phase checks
//                every cycle against a rule-level reference model.
//  Ports       : none
//  Revision    : 1.0  initial release
// ============================================================================
module tb_game_flow_ctrl;

   localparam int NL  = 3;
   localparam int LVL = 2;
   localparam int ML  = 3;
   localparam int LW  = 2;
   localparam int CD  = 3;
   localparam int CW  = 2;
   localparam int TW  = 3;
   localparam int TMAX = (1 << TW) - 1;

   // one-hot patterns {choose, ready, playing, pause, over, win}
   localparam logic [5:0] E_CHOOSE = 6'b100000;
   localparam logic [5:0] E_READY  = 6'b010000;
   localparam logic [5:0] E_PLAY   = 6'b001000;
   localparam logic [5:0] E_PAUSE  = 6'b000100;
   localparam logic [5:0] E_OVER   = 6'b000010;
   localparam logic [5:0] E_WIN    = 6'b000001;

   logic clk;
   logic rstn;
   int   n_checks;
   int   n_pass;

   game_flow_ctrl_if #(.LVL_W(LVL), .LIFE_W(LW), .CNT_W(CW), .TIME_W(TW)) bus ();

   game_flow_ctrl #(
      .NUM_LEVELS (NL),
      .LVL_W      (LVL),
      .MAX_LIVES  (ML),
      .LIFE_W     (LW),
      .COUNTDOWN  (CD),
      .CNT_W      (CW),
      .TIME_W     (TW)
   ) u_dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------------------
   // Reference model: game rules in plain integers
   // ------------------------------------------------------------------------
   typedef enum int {M_CHOOSE, M_READY, M_PLAY, M_PAUSE, M_OVER, M_WIN} mode_t;
   mode_t m_mode;
   int    m_level, m_lives, m_cd, m_pt;

   function automatic void model_reset();
      m_mode  = M_CHOOSE;
      m_level = 0;
      m_lives = ML;
      m_cd    = CD;
      m_pt    = 0;
   endfunction

   function automatic void model_update();
      if (m_mode != M_CHOOSE && bus.restart) begin
         m_mode = M_CHOOSE;
         return;
      end
      case (m_mode)
         M_CHOOSE: if (bus.start) begin
            m_level = (int'(bus.level_sel) > NL - 1) ? NL - 1 : int'(bus.level_sel);
            m_lives = ML;
            m_cd    = CD;
            m_pt    = 0;
            m_mode  = M_READY;
         end
         M_READY: if (bus.tick) begin
            m_cd = m_cd - 1;
            if (m_cd == 0) m_mode = M_PLAY;
         end
         M_PLAY: begin
            if (bus.tick && m_pt < TMAX) m_pt = m_pt + 1;
            if (bus.pause) m_mode = M_PAUSE;
            else if (bus.life_lost) begin
               m_lives = m_lives - 1;
               if (m_lives == 0) m_mode = M_OVER;
               else begin m_cd = CD; m_mode = M_READY; end
            end else if (bus.level_clear) begin
               if (m_level == NL - 1) m_mode = M_WIN;
               else begin m_level = m_level + 1; m_cd = CD; m_mode = M_READY; end
            end
         end
         M_PAUSE: if (bus.esc_pause) m_mode = M_PLAY;
         default: ;
      endcase
   endfunction

   function automatic logic [5:0] en_vec();
      return {bus.choose_en, bus.ready_en, bus.playing_en,
              bus.pause_en, bus.over_en, bus.win_en};
   endfunction

   // ------------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------------
   task automatic idle();
      bus.tick = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
      bus.esc_pause = 1'b0; bus.restart = 1'b0; bus.level_clear = 1'b0;
      bus.life_lost = 1'b0; bus.level_sel = '0;
   endtask

   // One clock edge; model advances on the same inputs the DUT sampled
   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      idle();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         bus.tick = 1'b1;
         step();
      end
   endtask

   task automatic start_game(input logic [LVL-1:0] sel);
      bus.level_sel = sel;
      bus.start     = 1'b1;
      step();
   endtask

   // ------------------------------------------------------------------------
   // Scenarios
   // ------------------------------------------------------------------------
   task automatic test_reset();
      idle();
      rstn = 1'b0;
      model_reset();
      #12;
      n_checks++;
      if (en_vec() !== E_CHOOSE || bus.level !== 2'd0 || bus.lives !== 2'd3 ||
          bus.countdown !== 2'd3 || bus.play_time !== 3'd0)
         $display("FAIL reset: en=%b lvl=%0d lives=%0d cd=%0d pt=%0d, required en=%b lvl=0 lives=3 cd=3 pt=0",
                  en_vec(), bus.level, bus.lives, bus.countdown, bus.play_time, E_CHOOSE);
      else n_pass++;
      #2 rstn = 1'b1;
   endtask

   task automatic test_countdown();
      start_game(2'd1);
      n_checks++;
      if (en_vec() !== E_READY || bus.countdown !== 2'd3 || bus.level !== 2'd1 || bus.lives !== 2'd3)
         $display("FAIL start_ready: en=%b cd=%0d lvl=%0d lives=%0d, required en=%b cd=3 lvl=1 lives=3",
                  en_vec(), bus.countdown, bus.level, bus.lives, E_READY);
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         logic [5:0] exp_en;
         logic [1:0] exp_cd;
         exp_en = (i == 2) ? E_PLAY : E_READY;
         exp_cd = 2'(2 - i);
         ticks(1);
         n_checks++;
         if (en_vec() !== exp_en || bus.countdown !== exp_cd || bus.level !== 2'd1 || bus.lives !== 2'd3)
            $display("FAIL countdown_%0d: en=%b cd=%0d lvl=%0d lives=%0d, required en=%b cd=%0d lvl=1 lives=3",
                     i, en_vec(), bus.countdown, bus.level, bus.lives, exp_en, exp_cd);
         else n_pass++;
      end
   endtask

   task automatic test_lives();
      for (int k = 0; k < 3; k++) begin
         bus.life_lost = 1'b1;
         step();
         n_checks++;
         if (k < 2) begin
            if (en_vec() !== E_READY || bus.lives !== 2'(2 - k) || bus.countdown !== 2'd3)
               $display("FAIL life_lost_%0d: en=%b lives=%0d cd=%0d, required en=%b lives=%0d cd=3",
                        k, en_vec(), bus.lives, bus.countdown, E_READY, 2 - k);
            else n_pass++;
            ticks(3);
         end else begin
            if (en_vec() !== E_OVER || bus.lives !== 2'd0)
               $display("FAIL game_over: en=%b lives=%0d, required en=%b lives=0",
                        en_vec(), bus.lives, E_OVER);
            else n_pass++;
         end
      end
      bus.restart = 1'b1;
      step();
      n_checks++;
      if (en_vec() !== E_CHOOSE || bus.lives !== 2'd0)
         $display("FAIL restart_over: en=%b lives=%0d, required en=%b lives=0 (held)",
                  en_vec(), bus.lives, E_CHOOSE);
      else n_pass++;
   endtask

   task automatic test_level_overflow();
      start_game(2'd3);
      n_checks++;
      if (bus.level !== 2'd2)
         $display("FAIL level_clamp: level=%0d, required 2", bus.level);
      else n_pass++;
      ticks(3);
      bus.level_clear = 1'b1;
      step();
      bus.level_clear = 1'b1;
      step();
      n_checks++;
      if (en_vec() !== E_WIN || bus.level !== 2'd2)
         $display("FAIL win_sticky: en=%b level=%0d, required en=%b level=2",
                  en_vec(), bus.level, E_WIN);
      else n_pass++;
      bus.restart = 1'b1;
      step();
   endtask

   task automatic test_play_time();
      start_game(2'd0);
      ticks(3);
      ticks(5);
      bus.pause = 1'b1;
      step();
      ticks(4);
      n_checks++;
      if (en_vec() !== E_PAUSE || bus.play_time !== 3'd5)
         $display("FAIL pause_frozen: en=%b pt=%0d, required en=%b pt=5",
                  en_vec(), bus.play_time, E_PAUSE);
      else n_pass++;
      bus.esc_pause = 1'b1;
      step();
      ticks(2);
      n_checks++;
      if (en_vec() !== E_PLAY || bus.play_time !== 3'd7)
         $display("FAIL play_time: en=%b pt=%0d, required en=%b pt=7",
                  en_vec(), bus.play_time, E_PLAY);
      else n_pass++;
      bus.pause = 1'b1;
      step();
      bus.pause = 1'b1;
      bus.esc_pause = 1'b1;
      step();
      n_checks++;
      if (en_vec() !== E_PLAY)
         $display("FAIL esc_wins: en=%b, required %b", en_vec(), E_PLAY);
      else n_pass++;
      bus.restart = 1'b1;
      step();
   endtask

   task automatic test_simultaneous();
      start_game(2'd1);
      ticks(3);
      bus.life_lost = 1'b1;
      step();
      ticks(3);
      bus.life_lost   = 1'b1;
      bus.level_clear = 1'b1;
      step();
      n_checks++;
      if (en_vec() !== E_READY || bus.lives !== 2'd1 || bus.level !== 2'd1)
         $display("FAIL lost_and_clear: en=%b lives=%0d lvl=%0d, required en=%b lives=1 lvl=1",
                  en_vec(), bus.lives, bus.level, E_READY);
      else n_pass++;
      ticks(3);
      bus.restart = 1'b1;
      bus.pause   = 1'b1;
      bus.tick    = 1'b1;
      step();
      n_checks++;
      if (en_vec() !== E_CHOOSE || bus.play_time !== 3'd0)
         $display("FAIL restart_pause: en=%b pt=%0d, required en=%b pt=0",
                  en_vec(), bus.play_time, E_CHOOSE);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      start_game(2'd2);
      ticks(1);
      #3;
      rstn = 1'b0;
      #1;
      n_checks++;
      if (en_vec() !== E_CHOOSE || bus.countdown !== 2'd3 || bus.level !== 2'd0 ||
          bus.lives !== 2'd3 || bus.play_time !== 3'd0)
         $display("FAIL async_reset: en=%b cd=%0d lvl=%0d lives=%0d pt=%0d, required en=%b cd=3 lvl=0 lives=3 pt=0",
                  en_vec(), bus.countdown, bus.level, bus.lives, bus.play_time, E_CHOOSE);
      else n_pass++;
      model_reset();
      #1 rstn = 1'b1;
   endtask

   task automatic test_saturation();
      start_game(2'd0);
      ticks(3);
      ticks(9);
      n_checks++;
      if (bus.play_time !== 3'd7 || en_vec() !== E_PLAY)
         $display("FAIL saturate: pt=%0d en=%b, required pt=7 en=%b",
                  bus.play_time, en_vec(), E_PLAY);
      else n_pass++;
      bus.restart = 1'b1;
      step();
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      for (int c = 0; c < 600; c++) begin
         logic [16:0] got;
         logic [16:0] exp;
         bus.tick        = ($urandom_range(0, 1) == 1);
         bus.start       = ($urandom_range(0, 3) == 0);
         bus.pause       = ($urandom_range(0, 9) == 0);
         bus.esc_pause   = ($urandom_range(0, 4) == 0);
         bus.restart     = ($urandom_range(0, 39) == 0);
         bus.level_clear = ($urandom_range(0, 11) == 0);
         bus.life_lost   = ($urandom_range(0, 11) == 0);
         bus.level_sel   = LVL'($urandom_range(0, 3));
         step();
         got = {en_vec(), bus.level, bus.lives, bus.countdown, bus.play_time};
         exp = {E_CHOOSE >> int'(m_mode), LVL'(m_level), LW'(m_lives), CW'(m_cd), TW'(m_pt)};
         n_checks++;
         if (got !== exp) begin
            if (errs < 10)
               $display("FAIL random_cycle_%0d: got {en,lvl,lives,cd,pt}=%b, required %b", c, got, exp);
            errs++;
         end else n_pass++;
      end
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rstn     = 1'b0;
      idle();
      test_reset();
      @(negedge clk);
      test_countdown();
      test_lives();
      test_level_overflow();
      test_play_time();
      test_simultaneous();
      test_async_reset();
      test_saturation();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Top-level game-flow sequencer and parametrised successor of the four-state choose/play/pause/over controller. It adds a pre-round countdown, multi-level progression, a life counter, a win state and a play-time counter. It sits between the debounced button/event pulses and the display/game-logic blocks, which consume its one-hot state enables and status counters. All state and counters are registered; outputs are glitch-free decodes of registered state.

## Interface
- NUM_LEVELS, 4, number of levels (>=1); the last level is NUM_LEVELS-1
- LVL_W, 2, width of level fields (2^LVL_W >= NUM_LEVELS)
- MAX_LIVES, 3, lives loaded at game start (>=1)
- LIFE_W, 2, width of lives (2^LIFE_W > MAX_LIVES)
- COUNTDOWN, 3, countdown ticks before each round (>=1)
- CNT_W, 2, width of countdown (2^CNT_W > COUNTDOWN)
- TIME_W, 10, width of play-time counter
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle time-base strobe (e.g. 1 Hz)
- start  in  1  leave CHOOSE
- pause  in  1  request pause
- esc_pause  in  1  leave pause
- restart  in  1  return to CHOOSE from any state
- level_sel  in  LVL_W  starting level, sampled on start
- level_clear  in  1  current level completed (pulse)
- life_lost  in  1  player died (pulse)
- choose_en, ready_en, playing_en, pause_en, over_en, win_en  out  1 each  one-hot state decode
- level  out  LVL_W  current level
- lives  out  LIFE_W  remaining lives
- countdown  out  CNT_W  remaining countdown ticks
- play_time  out  TIME_W  ticks spent in PLAYING this game

## Operation
- States: CHOOSE, READY, PLAYING, PAUSE, OVER, WIN. Exactly one *_en is high at all times.
- All inputs are sampled at the rising edge of clk. An input held high acts again on every cycle it is sampled.
- restart has top priority in every state except CHOOSE: next state CHOOSE; level, lives, countdown and play_time keep their values until the next start.
- CHOOSE: on start -> READY. Load level = min(level_sel, NUM_LEVELS-1), lives = MAX_LIVES, countdown = COUNTDOWN, play_time = 0. All other inputs are ignored.
- READY: each tick decrements countdown. A tick while countdown==1 sets countdown to 0 and moves to PLAYING. pause, level_clear and life_lost are ignored.
- PLAYING, priority after restart is pause > life_lost > level_clear:
  - pause -> PAUSE.
  - life_lost: lives -= 1. If lives was 1, go to OVER with lives = 0. Otherwise reload countdown and go to READY.
  - level_clear: if level == NUM_LEVELS-1, go to WIN. Otherwise level += 1, reload countdown and go to READY.
  - tick increments play_time, saturating at 2^TIME_W-1. A tick is counted even on a cycle that also leaves PLAYING.
- PAUSE: esc_pause -> PLAYING. pause, tick, life_lost and level_clear are ignored; no counter moves.
- OVER, WIN: only restart has an effect.
- Illegal state encoding: recover to CHOOSE on the next edge.

## Timing
- Reset (rstn low, asynchronous): state CHOOSE, choose_en=1, other enables 0, level=0, lives=MAX_LIVES, countdown=COUNTDOWN, play_time=0. Reset takes effect immediately, including mid-countdown or mid-pause.
- Event sampled at edge N: the state and counter updates are visible after edge N, i.e. 1-cycle latency. Outputs are combinational decodes of registers only and have no input-to-output path.
- READY lasts exactly COUNTDOWN ticks. With back-to-back ticks, PLAYING is entered COUNTDOWN cycles after entering READY.
- Simultaneous pause and esc_pause in PAUSE: esc_pause wins.
- Simultaneous life_lost and level_clear in PLAYING: only life_lost is applied.
- restart together with any other input: only restart is applied.

## Test plan
- Reset, then start with level_sel=1, then 3 ticks: READY is shown with countdown 3,2,1; PLAYING is entered with countdown 0, level=1, lives=3.
- In PLAYING, life_lost three times, each followed by a full countdown: lives go 2, 1; the third life_lost gives OVER with lives=0. restart then gives CHOOSE.
- level_sel=3 (overflow test with NUM_LEVELS=3): level loads as 2. level_clear in PLAYING gives WIN; a further level_clear has no effect.
- PLAYING with 5 ticks, pause, 4 ticks, esc_pause, 2 ticks: play_time=7. pause and esc_pause asserted together while in PAUSE returns to PLAYING.
- life_lost and level_clear in the same cycle with lives=2: lives becomes 1, level is unchanged, state goes to READY. restart together with pause gives CHOOSE.
- Assert rstn mid-READY with countdown=2: outputs return to reset values immediately, before the next edge. With TIME_W=3 and 9 ticks in PLAYING, play_time saturates at 7.
